// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
//
// This block debounces one active-low mechanical key. The key input is
// asynchronous to sys_clk. It first passes through a two-flop synchronizer.
// A four-state FSM with a shared filter counter then confirms each level
// change. A change is confirmed only after the synchronized level has stayed
// stable for CNT_MAX+1 consecutive cycles.
//
// Parameters
//   CNT_MAX     : filter length minus one, in sys_clk cycles. Must be >= 1.
//                 The default gives 20 ms at 50 MHz.
//
// Ports
//   sys_clk     : in  - system clock. All state updates on its rising edge.
//   sys_rst     : in  - asynchronous reset, active low.
//   key_in      : in  - raw key, active low (0 = pressed), asynchronous.
//   key_flag    : out - registered one-cycle pulse on each confirmed press.
//   key_release : out - registered one-cycle pulse on each confirmed release.
//   key_state   : out - registered debounced level, 1 = pressed.
// ---------------------------------------------------------------------------
module key_filter #(
    parameter int CNT_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_release,
    output logic key_state
);

    // The counter must be able to hold CNT_MAX itself.
    localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PRESS_FILT = 2'b01,
        DOWN       = 2'b10,
        REL_FILT   = 2'b11
    } state_t;

    // Synchronizer flops. Both reset to the released level (1).
    logic sync1_q;
    logic sync2_q;
    logic sync_key;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            flag_q;
    logic            flag_d;
    logic            rel_q;
    logic            rel_d;
    logic            kstate_q;
    logic            kstate_d;

    assign sync_key = sync2_q;

    // Two-flop synchronizer. Only the second stage may reach the FSM.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, filter counter and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            flag_q   <= 1'b0;
            rel_q    <= 1'b0;
            kstate_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            rel_q    <= rel_d;
            kstate_q <= kstate_d;
        end
    end

    // Next-state logic. The counter clears on every transition. Pulses are
    // raised only on the edge that confirms a level change, and key_state
    // moves on that same edge. A bounce inside a filter state returns to the
    // prior stable state silently.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flag_d   = 1'b0;
        rel_d    = 1'b0;
        kstate_d = kstate_q;

        case (state_q)
            IDLE: begin
                if (!sync_key) begin
                    state_d = PRESS_FILT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            PRESS_FILT: begin
                if (sync_key) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = DOWN;
                    cnt_d    = CNT_ZERO;
                    flag_d   = 1'b1;
                    kstate_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DOWN: begin
                if (sync_key) begin
                    state_d = REL_FILT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            REL_FILT: begin
                if (!sync_key) begin
                    state_d = DOWN;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = CNT_ZERO;
                    rel_d    = 1'b1;
                    kstate_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = CNT_ZERO;
                kstate_d = 1'b0;
            end
        endcase
    end

    assign key_flag    = flag_q;
    assign key_release = rel_q;
    assign key_state   = kstate_q;

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 999_999, giving the filter length minus one in sys_clk cycles (20 ms at 50 MHz); legal range >= 1.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port key_in, input, 1 bit: raw mechanical key, asynchronous to sys_clk, active-low (0 = pressed).
REQ-005 The block SHALL have port key_flag, output, 1 bit: one-cycle pulse on each confirmed press; this is the strobe consumed by the downstream LED/reset-demo logic.
REQ-006 The block SHALL have port key_release, output, 1 bit: one-cycle pulse on each confirmed release.
REQ-007 The block SHALL have port key_state, output, 1 bit: debounced level, 1 = pressed.

Function
REQ-008 key_in SHALL pass through a two-flop synchronizer whose flops reset to 1 (released); only the second-stage output (sync_key) drives the FSM.
REQ-009 The FSM SHALL have exactly four states: IDLE, PRESS_FILT, DOWN, REL_FILT.
REQ-010 The filter counter SHALL be $clog2(CNT_MAX+1) bits wide, unsigned, and SHALL clear to 0 on every state transition.
REQ-011 IDLE: sync_key=0 -> PRESS_FILT with cnt=0; otherwise stay.
REQ-012 PRESS_FILT: sync_key=1 -> IDLE with no pulse; sync_key=0 and cnt<CNT_MAX -> cnt+1; sync_key=0 and cnt==CNT_MAX -> DOWN.
REQ-013 On PRESS_FILT->DOWN, key_flag SHALL be registered high for exactly one cycle and key_state SHALL go to 1 on the same edge.
REQ-014 DOWN: sync_key=1 -> REL_FILT with cnt=0; otherwise stay.
REQ-015 REL_FILT: sync_key=0 -> DOWN with no pulse; sync_key=1 and cnt<CNT_MAX -> cnt+1; sync_key=1 and cnt==CNT_MAX -> IDLE.
REQ-016 On REL_FILT->IDLE, key_release SHALL be high for exactly one cycle and key_state SHALL go to 0 on the same edge.
REQ-017 Latency: for a key_in that goes low and stays low, key_flag SHALL be high during the cycle following the (CNT_MAX+4)th rising edge, counting the first edge that samples key_in=0 as edge 1; key_release SHALL have the same latency relative to a stable high.
REQ-018 Any sync_key bounce inside a filter state SHALL restart filtering from the prior stable state; the number of pulses SHALL equal the number of confirmed level changes.
REQ-019 key_flag and key_release SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-020 key_state SHALL change only on the edges where key_flag or key_release is asserted.

Reset
REQ-021 sys_rst=0 SHALL immediately and asynchronously force state=IDLE, cnt=0, synchronizer flops=1, key_flag=0, key_release=0, key_state=0.
REQ-022 Reset asserted mid-filter or in DOWN SHALL emit no pulse, either during reset or on its release.
REQ-023 If key_in is held low across reset deassertion, the block SHALL run a full press filter and then emit exactly one key_flag.

Verification (bench overrides CNT_MAX=9)
REQ-024 Test 1: key_in low, held 30 cycles after reset release -> one key_flag pulse after edge 13; key_state=1 from edge 13 onward; key_release stays 0.
REQ-025 Test 2: bounce key_in low 5 cycles / high 1 / low 3 / high 1, then low steady -> no pulse during the bounce; key_flag after edge 13 counted from the final falling sample.
REQ-026 Test 3: from DOWN, key_in high steady -> one key_release pulse after edge 13; key_state=0 on that edge.
REQ-027 Test 4: key_in randomized every 20 ns (toggling no slower than every 2 cycles) for 500 cycles from IDLE -> key_flag=key_release=0 throughout; key_state=0.
REQ-028 Test 5: sys_rst pulsed low at cnt=5 in PRESS_FILT, and again while in DOWN -> outputs 0 immediately (mid-cycle); no key_flag or key_release is ever emitted as a result of either reset.
REQ-029 Test 6: key held low through reset release -> exactly one key_flag, 13 edges after the first post-reset edge.
